apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream APB requester: converts single-beat commands from a local valid/ready port into legal APB SETUP→ACCESS transfers on the shared APB signal set.
- Returns read data and error status on a held response port.
- Sits between the CPU/DMA-side command source and the APB interface/slaves.
- Adds a bounded-wait timeout so a hung slave cannot stall the requester.

Parameters:
- ADDR_W, 32, APB address width (Paddr width).
- DATA_W, 32, APB data width (Pwdata/Prdata width).
- TIMEOUT, 16, max ACCESS cycles waiting for Pready; 0 disables the timeout.

Ports:
- Pclk  input  1  clock, rising edge.
- Prst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  byte address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response available; held until rsp_ready.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  DATA_W  read data (0 for writes/errors).
- rsp_slverr  output  1  slave error, timeout or misalignment.
- rsp_timeout  output  1  error caused by timeout.
- Paddr  output  ADDR_W  APB address.
- Pselx  output  1  APB select.
- Penable  output  1  APB enable.
- Pwrite  output  1  APB direction.
- Pwdata  output  DATA_W  APB write data.
- Pready  input  1  slave ready.
- Pslverr  input  1  slave error.
- Prdata  input  DATA_W  slave read data.

Behaviour:
- Reset: Prst is asynchronous, active-high. All outputs are registered and reset to 0; state = IDLE; timeout counter = 0.
- States: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1. On accept with cmd_addr[1:0]==0: latch addr/write/wdata into Paddr/Pwrite/Pwdata, go SETUP.
  - IDLE, misaligned accept (cmd_addr[1:0]!=0): no APB activity; go RESP with slverr=1, timeout=0, rdata=0.
  - SETUP: Pselx=1, Penable=0, lasting exactly one cycle; next state is ACCESS unconditionally.
  - ACCESS: Pselx=1, Penable=1. Paddr/Pwrite/Pwdata held stable.
    - On Pready=1: capture Prdata (reads only, else 0) and Pslverr; deassert Pselx/Penable next cycle; go RESP.
  - RESP: Pselx=0, Penable=0, rsp_valid=1, response fields stable. On rsp_ready go IDLE.
- cmd_ready=0 in SETUP, ACCESS and RESP. rsp_valid=0 outside RESP.
- Latency: accept at edge N → SETUP cycle N+1 → ACCESS cycle N+2. Zero-wait slave gives rsp_valid in cycle N+3.
- Throughput: minimum 4 cycles per transfer with rsp_ready tied 1. No back-to-back without an IDLE cycle.
- Pselx never high with Penable high unless preceded by exactly one SETUP cycle. Penable is never 1 while Pselx=0.
- Idle bus: Paddr/Pwrite/Pwdata retain last values (no toggling).
- Timeout (TIMEOUT>0): counter increments each ACCESS cycle with Pready=0 and clears on entering ACCESS.
  - If Pready is still 0 in the TIMEOUT-th ACCESS cycle: abort. Pselx/Penable drop next cycle; RESP with slverr=1, timeout=1, rdata=0.
  - Pready=1 in that same cycle wins: normal completion, no timeout.
  - Counter width is $clog2(TIMEOUT+1).
- Pslverr is sampled only in the Pready=1 ACCESS cycle. It is ignored at all other times.
- Reset asserted mid-transfer: bus returns to idle (all 0) immediately and asynchronously. The in-flight command is dropped with no response.

Decomposition:
- apb_pkg holds:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP};
  - response struct {rdata, slverr, timeout};
  - localparam for the alignment mask.
- One sub-module: apb_timeout_ctr. Inputs: clr, inc. Output: expired. Parameterised by TIMEOUT. When TIMEOUT=0 it is constant expired=0.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, Pready=1 immediately → SETUP one cycle, ACCESS one cycle with Paddr=0x10, Pwdata=0xDEADBEEF, Pwrite=1; rsp_valid at N+3, slverr=0.
- Read addr 0x20, slave asserts Pready after 3 wait cycles with Prdata=0x12345678 → Paddr stable across all 4 ACCESS cycles; rsp_rdata=0x12345678.
- Read, Pslverr=1 with Pready → rsp_slverr=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT=16, Pready held 0 → exactly 16 ACCESS cycles, then Pselx=0; rsp_slverr=1, rsp_timeout=1. Variant with Pready=1 in cycle 16 → normal completion.
- cmd_addr=0x13 → Pselx never asserts; rsp_valid 1 cycle after accept, slverr=1. Also rsp_ready held 0 for 5 cycles → response fields stable and cmd_ready=0 throughout.
- Prst pulsed during ACCESS → Pselx/Penable/rsp_valid go 0 asynchronously. Next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM states, the held response record
// and the word-alignment helpers used when a command is accepted.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  // APB data paths are at most 32 bits wide.
  localparam int APB_MAX_DATA_W = 32;

  // Byte-offset bits that must be zero for a legal word access.
  localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic [APB_MAX_DATA_W-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
  } apb_rsp_t;

  localparam apb_rsp_t APB_RSP_NONE = '{rdata: '0, slverr: 1'b0, timeout: 1'b0};

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & APB_ALIGN_MASK) == 2'b00;
  endfunction

  // Error responses never carry read data.
  function automatic apb_rsp_t rsp_error(input logic timed_out);
    apb_rsp_t rsp;
    rsp.rdata   = '0;
    rsp.slverr  = 1'b1;
    rsp.timeout = timed_out;
    return rsp;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for the bridge. The master modport is
// the bridge's view; the slave modport is the view of whatever surrounds it.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] Paddr;
  logic              Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [DATA_W-1:0] Pwdata;
  logic              Pready;
  logic              Pslverr;
  logic [DATA_W-1:0] Prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output Paddr, Pselx, Penable, Pwrite, Pwdata,
    input  Pready, Pslverr, Prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  Paddr, Pselx, Penable, Pwrite, Pwdata,
    output Pready, Pslverr, Prdata
  );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS cycles that end without Pready and flags the cycle in which the
// wait budget runs out. TIMEOUT=0 removes the counter entirely.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, clr, inc};
      assign expired  = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT + 1);

      logic [CNT_W-1:0] r_count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (clr) begin
          r_count <= '0;
        end else if (inc) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      // r_count holds the number of earlier stalled ACCESS cycles, so the
      // TIMEOUT-th stalled cycle is the one that sees TIMEOUT-1.
      assign expired = inc && (r_count == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Single-beat APB requester: turns valid/ready commands into SETUP->ACCESS
// transfers and returns a held response, with a bounded wait on Pready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                Pclk,
  input  logic                Prst,
  apb_master_bridge_if.master bus
);

  apb_mst_state_e    r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  apb_rsp_t          r_rsp;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;

  logic w_to_clr;
  logic w_to_inc;
  logic w_to_expired;

  assign w_to_clr = (r_state == SETUP);
  assign w_to_inc = (r_state == ACCESS) && !bus.Pready;

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (Pclk),
    .rst     (Prst),
    .clr     (w_to_clr),
    .inc     (w_to_inc),
    .expired (w_to_expired)
  );

  // NOTE: every register here uses non-blocking assignments so all of them
  // sample pre-edge values and the state/output updates land together.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= APB_RSP_NONE;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // cmd_ready is a register, so it rises one cycle after reset.
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (is_aligned(bus.cmd_addr[1:0])) begin
              r_paddr  <= bus.cmd_addr;
              r_pwrite <= bus.cmd_write;
              r_pwdata <= bus.cmd_wdata;
              r_psel   <= 1'b1;
              r_state  <= SETUP;
            end else begin
              r_rsp       <= rsp_error(1'b0);
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end

        ACCESS: begin
          if (bus.Pready) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp.rdata  <= (r_pwrite || bus.Pslverr) ? '0 : APB_MAX_DATA_W'(bus.Prdata);
            r_rsp.slverr <= bus.Pslverr;
            r_rsp.timeout <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else if (w_to_expired) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp       <= rsp_error(1'b1);
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp.rdata[DATA_W-1:0];
  assign bus.rsp_slverr  = r_rsp.slverr;
  assign bus.rsp_timeout = r_rsp.timeout;
  assign bus.Paddr       = r_paddr;
  assign bus.Pselx       = r_psel;
  assign bus.Penable     = r_penable;
  assign bus.Pwrite      = r_pwrite;
  assign bus.Pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised scoreboard bench for apb_master_bridge: a scripted APB slave, an
// APB protocol monitor and a response monitor checked against a transfer model.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] rdata;
    bit          slverr;
    bit          tmo;
    int          lat;
    int          accept_edge;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          write;
    logic [31:0] wdata;
    int          n_acc;
  } apb_exp_t;

  typedef struct {
    int          wt;
    bit          err;
    logic [31:0] data;
  } slv_plan_t;

  logic Pclk;
  logic Prst;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Pclk (Pclk),
    .Prst (Prst),
    .bus  (bus)
  );

  rsp_exp_t  exp_q[$];
  apb_exp_t  apb_q[$];
  slv_plan_t slv_q[$];

  int n_checks;
  int n_fail;
  int edge_cnt;
  int rsp_hold;
  bit in_rsp;

  initial begin
    Pclk = 1'b0;
    forever #5 Pclk = ~Pclk;
  end

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge Pclk);
      edge_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: answers the n-th ACCESS cycle of each transfer from its plan and
  // drives noise on Pready/Pslverr/Prdata whenever it is not answering.
  initial begin
    int        acc;
    slv_plan_t plan;
    acc  = 0;
    plan = '{wt: 1000, err: 1'b0, data: '0};
    bus.Pready  = 1'b0;
    bus.Pslverr = 1'b0;
    bus.Prdata  = '0;
    forever begin
      @(negedge Pclk);
      if (Prst) begin
        acc         = 0;
        bus.Pready  = 1'b0;
        bus.Pslverr = 1'b0;
      end else if (bus.Pselx && bus.Penable) begin
        acc++;
        if (acc == 1) begin
          if (slv_q.size() > 0) plan = slv_q.pop_front();
          else plan = '{wt: 1000, err: 1'b0, data: '0};
        end
        if (acc == plan.wt + 1) begin
          bus.Pready  = 1'b1;
          bus.Pslverr = plan.err;
          bus.Prdata  = plan.data;
        end else begin
          bus.Pready  = 1'b0;
          bus.Pslverr = 1'($urandom_range(0, 1));
          bus.Prdata  = $urandom;
        end
      end else begin
        acc         = 0;
        bus.Pready  = 1'($urandom_range(0, 1));
        bus.Pslverr = 1'($urandom_range(0, 1));
        bus.Prdata  = $urandom;
      end
    end
  end

  // APB protocol monitor.
  initial begin
    int          phase;
    int          n_acc;
    apb_exp_t    cur;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic        last_write;
    phase = 0;
    n_acc = 0;
    cur   = '{addr: '0, write: 1'b0, wdata: '0, n_acc: 0};
    last_addr  = '0;
    last_wdata = '0;
    last_write = 1'b0;
    forever begin
      @(negedge Pclk);
      if (Prst) begin
        phase      = 0;
        n_acc      = 0;
        last_addr  = '0;
        last_wdata = '0;
        last_write = 1'b0;
      end else begin
        check("penable_without_psel", 32'(bus.Penable & ~bus.Pselx), 0);
        if (bus.Pselx) check("cmd_ready_while_busy", 32'(bus.cmd_ready), 0);
        case (phase)
          0: begin
            if (bus.Pselx) begin
              check("setup_penable", 32'(bus.Penable), 0);
              if (apb_q.size() == 0) begin
                check("unexpected_transfer", 1, 0);
                cur = '{addr: bus.Paddr, write: bus.Pwrite, wdata: bus.Pwdata, n_acc: 0};
              end else begin
                cur = apb_q.pop_front();
              end
              check("setup_paddr", bus.Paddr, cur.addr);
              check("setup_pwrite", 32'(bus.Pwrite), 32'(cur.write));
              check("setup_pwdata", bus.Pwdata, cur.wdata);
              last_addr  = bus.Paddr;
              last_write = bus.Pwrite;
              last_wdata = bus.Pwdata;
              phase      = 1;
            end else begin
              check("idle_paddr_held", bus.Paddr, last_addr);
              check("idle_pwrite_held", 32'(bus.Pwrite), 32'(last_write));
              check("idle_pwdata_held", bus.Pwdata, last_wdata);
            end
          end
          1: begin
            check("access_follows_one_setup", {30'd0, bus.Pselx, bus.Penable}, 3);
            n_acc = 1;
            check("access_paddr_stable", bus.Paddr, cur.addr);
            check("access_pwdata_stable", bus.Pwdata, cur.wdata);
            phase = (bus.Pselx && bus.Penable) ? 2 : 0;
          end
          2: begin
            if (bus.Pselx && bus.Penable) begin
              n_acc++;
              check("access_paddr_stable", bus.Paddr, cur.addr);
              check("access_pwrite_stable", 32'(bus.Pwrite), 32'(cur.write));
              check("access_pwdata_stable", bus.Pwdata, cur.wdata);
            end else begin
              check("access_cycles", n_acc, cur.n_acc);
              check("bus_released", {30'd0, bus.Pselx, bus.Penable}, 0);
              phase = 0;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response, then holds it
  // to its first value until the handshake it drives completes.
  initial begin
    rsp_exp_t    cur;
    logic [31:0] h_rdata;
    logic        h_slverr;
    logic        h_tmo;
    cur      = '{rdata: '0, slverr: 1'b0, tmo: 1'b0, lat: 0, accept_edge: 0};
    h_rdata  = '0;
    h_slverr = 1'b0;
    h_tmo    = 1'b0;
    in_rsp   = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge Pclk);
      if (Prst) begin
        in_rsp        = 1'b0;
        bus.rsp_ready = 1'b0;
      end else if (bus.rsp_valid) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            check("unexpected_response", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, cur.rdata);
            check("rsp_slverr", 32'(bus.rsp_slverr), 32'(cur.slverr));
            check("rsp_timeout", 32'(bus.rsp_timeout), 32'(cur.tmo));
            check("rsp_latency", edge_cnt - cur.accept_edge + 1, cur.lat);
          end
          h_rdata  = bus.rsp_rdata;
          h_slverr = bus.rsp_slverr;
          h_tmo    = bus.rsp_timeout;
          in_rsp   = 1'b1;
        end else begin
          check("rsp_rdata_stable", bus.rsp_rdata, h_rdata);
          check("rsp_slverr_stable", 32'(bus.rsp_slverr), 32'(h_slverr));
          check("rsp_timeout_stable", 32'(bus.rsp_timeout), 32'(h_tmo));
        end
        check("cmd_ready_during_resp", 32'(bus.cmd_ready), 0);
        if (rsp_hold > 0) begin
          rsp_hold--;
          bus.rsp_ready = 1'b0;
        end else begin
          bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        if (bus.rsp_ready) in_rsp = 1'b0;
      end else begin
        if (in_rsp) begin
          check("rsp_dropped_before_ready", 1, 0);
          in_rsp = 1'b0;
        end
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Issues one command once the bridge is ready and pushes the expected
  // outcome: misaligned -> immediate error; wait >= TIMEOUT -> timeout after
  // TIMEOUT ACCESS cycles; otherwise completion after wt+1 ACCESS cycles.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int wt, input bit err, input logic [31:0] rd, input int hold);
    int        t;
    rsp_exp_t  r;
    apb_exp_t  a;
    slv_plan_t s;
    t = 0;
    @(negedge Pclk);
    while (!bus.cmd_ready && t < 200) begin
      @(negedge Pclk);
      t++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
      return;
    end
    r.accept_edge = edge_cnt + 1;
    if (addr % 4 != 0) begin
      r.rdata = '0; r.slverr = 1'b1; r.tmo = 1'b0; r.lat = 1;
    end else begin
      if (wt >= TIMEOUT) begin
        r.rdata = '0; r.slverr = 1'b1; r.tmo = 1'b1; r.lat = TIMEOUT + 2;
        a.n_acc = TIMEOUT;
      end else begin
        r.rdata = (wr || err) ? 32'd0 : rd; r.slverr = err; r.tmo = 1'b0; r.lat = wt + 3;
        a.n_acc = wt + 1;
      end
      a.addr  = addr;
      a.write = wr;
      a.wdata = wdata;
      s = '{wt: wt, err: err, data: rd};
      apb_q.push_back(a);
      slv_q.push_back(s);
    end
    exp_q.push_back(r);
    rsp_hold      = hold;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(negedge Pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
  endtask

  initial begin
    int t;
    n_checks = 0;
    n_fail   = 0;
    rsp_hold = 0;
    Prst          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(negedge Pclk);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_pselx", 32'(bus.Pselx), 0);
    check("reset_penable", 32'(bus.Penable), 0);
    check("reset_paddr", bus.Paddr, 0);
    check("reset_pwdata", bus.Pwdata, 0);
    check("reset_pwrite", 32'(bus.Pwrite), 0);
    check("reset_rsp_fields", {29'd0, bus.rsp_slverr, bus.rsp_timeout, |bus.rsp_rdata}, 0);
    #2 Prst = 1'b0;

    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, $urandom, 0);
    issue(1'b0, 32'h20, $urandom, 3, 1'b0, 32'h1234_5678, 0);
    issue(1'b0, 32'h24, $urandom, 0, 1'b1, 32'hCAFE_F00D, 0);
    issue(1'b0, 32'h30, $urandom, TIMEOUT, 1'b0, $urandom, 0);
    issue(1'b1, 32'h34, 32'h0BAD_CAFE, TIMEOUT - 1, 1'b0, $urandom, 0);
    issue(1'b0, 32'h38, $urandom, TIMEOUT - 1, 1'b1, $urandom, 1);
    issue(1'b1, 32'h13, 32'h5555_AAAA, 0, 1'b0, $urandom, 5);

    // Reset in the middle of an ACCESS phase drops the command silently.
    issue(1'b0, 32'h40, $urandom, 10, 1'b0, $urandom, 0);
    t = 0;
    while (!bus.Penable && t < 20) begin
      @(negedge Pclk);
      t++;
    end
    check("reached_access_before_reset", 32'(bus.Penable), 1);
    @(posedge Pclk);
    #2;
    Prst = 1'b1;
    exp_q.delete();
    apb_q.delete();
    slv_q.delete();
    #1;
    check("async_reset_pselx", 32'(bus.Pselx), 0);
    check("async_reset_penable", 32'(bus.Penable), 0);
    check("async_reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("async_reset_paddr", bus.Paddr, 0);
    @(negedge Pclk);
    #2 Prst = 1'b0;
    issue(1'b0, 32'h44, $urandom, 1, 1'b0, 32'hA5A5_5A5A, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] addr;
      int          wt;
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) addr = addr | 32'($urandom_range(1, 3));
      wt = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 18));
      issue(1'($urandom_range(0, 1)), addr, $urandom, wt, ($urandom_range(0, 3) == 0),
            $urandom, int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) @(negedge Pclk);
    end

    t = 0;
    while ((exp_q.size() != 0 || in_rsp) && t < 400) begin
      @(negedge Pclk);
      t++;
    end
    check("responses_drained", exp_q.size(), 0);
    check("transfers_drained", apb_q.size(), 0);
    check("slave_plans_drained", slv_q.size(), 0);
    repeat (3) @(negedge Pclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
